// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared types and widths for the player input receiver
//
// Purpose: FSM state encoding, pattern/tick widths and a saturating tick
//          increment helper shared by the interface, the top and the bench.
// Ports:   none (package).

package game_pkg;

   localparam int unsigned PATTERN_W = 4;
   localparam int unsigned TICK_W    = 8;

   localparam logic [TICK_W-1:0] TICK_MAX = {TICK_W{1'b1}};

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ARMED  = 2'd1,
      ST_LOCKED = 2'd2
   } rx_state_t;

   // Reaction counter never wraps: once at TICK_MAX it stays there.
   function automatic logic [TICK_W-1:0] tick_sat_inc(input logic [TICK_W-1:0] v);
      return (v == TICK_MAX) ? v : v + TICK_W'(1);
   endfunction

endpackage

// File: rtl/player_input_rx_if.sv
// rtl/player_input_rx_if.sv - round control / answer handshake bundle
//
// Purpose: groups the game-logic side signals of the player input receiver.
// Signals: round_start, round_end, in_ack   (game logic -> receiver)
//          in_valid, in_pattern, reaction_ticks, timeout (receiver -> game logic)
// Modports: master = game logic, slave = receiver.

interface player_input_rx_if;
   import game_pkg::*;

   logic                 round_start;
   logic                 round_end;
   logic                 in_ack;
   logic                 in_valid;
   logic [PATTERN_W-1:0] in_pattern;
   logic [TICK_W-1:0]    reaction_ticks;
   logic                 timeout;

   modport master (
      output round_start, round_end, in_ack,
      input  in_valid, in_pattern, reaction_ticks, timeout
   );

   modport slave (
      input  round_start, round_end, in_ack,
      output in_valid, in_pattern, reaction_ticks, timeout
   );

endinterface

// File: rtl/sw_debounce.sv
// rtl/sw_debounce.sv - 2-flop synchronizer plus stability-count debouncer
//
// Purpose: brings the raw switch vector into the clock domain and only
//          accepts a new value once it has been constant for DEBOUNCE_CYCLES
//          consecutive cycles. SW-to-o_debounced latency is 2+DEBOUNCE_CYCLES.
// Ports:   i_clk       clock
//          i_rst       synchronous active-high reset
//          i_sw        raw asynchronous switches
//          o_debounced accepted switch vector (registered)

module sw_debounce
   import game_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 4
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic [PATTERN_W-1:0] i_sw,
   output logic [PATTERN_W-1:0] o_debounced
);

   localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [PATTERN_W-1:0] r_sync1;
   logic [PATTERN_W-1:0] r_sync2;
   logic [PATTERN_W-1:0] r_debounced;
   logic [CNT_W-1:0]     r_stable_cnt;

   // The count is restarted when the value about to enter r_sync2 differs
   // from the one already there, so r_stable_cnt == CNT_LAST means r_sync2
   // has been constant for DEBOUNCE_CYCLES edges including the current one.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_sync1      <= '0;
         r_sync2      <= '0;
         r_debounced  <= '0;
         r_stable_cnt <= '0;
      end else begin
         r_sync1 <= i_sw;
         r_sync2 <= r_sync1;
         if (r_sync1 != r_sync2) begin
            r_stable_cnt <= '0;
         end else if (r_stable_cnt != CNT_LAST) begin
            r_stable_cnt <= r_stable_cnt + CNT_W'(1);
         end else begin
            r_debounced <= r_sync2;
         end
      end
   end

   assign o_debounced = r_debounced;

endmodule

// File: rtl/player_input_rx.sv
// rtl/player_input_rx.sv - player switch receiver with reaction timer
//
// Purpose: debounces the player switches, arms on round_start, captures the
//          first change from the baseline (or the current vector on
//          round_end) and holds the answer until the game logic acks it.
// Ports:   board_clk  sole clock
//          rst_btn    synchronous active-high reset
//          SW         raw asynchronous player switches
//          bus        player_input_rx_if.slave (round control + answer)
// Config:  REACTION_TIMER_EN - builds the tick prescaler and reaction counter;
//          when undefined reaction_ticks is tied to 0.

module player_input_rx
   import game_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned TICK_DIV        = 10
) (
   input  logic                 board_clk,
   input  logic                 rst_btn,
   input  logic [PATTERN_W-1:0] SW,
   player_input_rx_if.slave     bus
);

   if (TICK_DIV < 1) begin : g_bad_tick_div
      $error("player_input_rx: TICK_DIV must be at least 1");
   end

   rx_state_t            r_state;
   rx_state_t            w_state_nx;
   logic                 r_in_valid;
   logic [PATTERN_W-1:0] r_in_pattern;
   logic                 r_timeout;
   logic [PATTERN_W-1:0] r_baseline;
   logic [PATTERN_W-1:0] w_debounced;
   logic                 w_valid_nx;
   logic                 w_capture;
   logic                 w_capture_to;
   logic                 w_latch_base;

   sw_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_sw_debounce (
      .i_clk       (board_clk),
      .i_rst       (rst_btn),
      .i_sw        (SW),
      .o_debounced (w_debounced)
   );

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge board_clk) begin
      if (rst_btn) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nx;
      end
   end

   // round_start is checked first so it beats round_end / in_ack in the same
   // cycle and restarts the round from any state. A switch change is checked
   // before round_end so a coincident change is never reported as a timeout.
   always_comb begin
      w_state_nx   = r_state;
      w_valid_nx   = r_in_valid;
      w_capture    = 1'b0;
      w_capture_to = 1'b0;
      w_latch_base = 1'b0;
      if (bus.round_start) begin
         w_state_nx   = ST_ARMED;
         w_valid_nx   = 1'b0;
         w_latch_base = 1'b1;
      end else begin
         unique case (r_state)
            ST_IDLE: begin
            end
            ST_ARMED: begin
               if (w_debounced != r_baseline) begin
                  w_state_nx = ST_LOCKED;
                  w_valid_nx = 1'b1;
                  w_capture  = 1'b1;
               end else if (bus.round_end) begin
                  w_state_nx   = ST_LOCKED;
                  w_valid_nx   = 1'b1;
                  w_capture    = 1'b1;
                  w_capture_to = 1'b1;
               end
            end
            ST_LOCKED: begin
               if (bus.in_ack && r_in_valid) begin
                  w_state_nx = ST_IDLE;
                  w_valid_nx = 1'b0;
               end
            end
            default: begin
               w_state_nx = ST_IDLE;
               w_valid_nx = 1'b0;
            end
         endcase
      end
   end

   // ------------------------------------------------------ answer registers
   always_ff @(posedge board_clk) begin
      if (rst_btn) begin
         r_in_valid   <= 1'b0;
         r_in_pattern <= '0;
         r_timeout    <= 1'b0;
         r_baseline   <= '0;
      end else begin
         r_in_valid <= w_valid_nx;
         if (w_latch_base) begin
            r_baseline <= w_debounced;
         end
         if (w_capture) begin
            r_in_pattern <= w_debounced;
            r_timeout    <= w_capture_to;
         end
      end
   end

   // ------------------------------------------------------- reaction timer
`ifdef REACTION_TIMER_EN
   localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

   logic [PRE_W-1:0]  r_prescale;
   logic [TICK_W-1:0] r_tick_cnt;
   logic [TICK_W-1:0] r_reaction_ticks;
   logic              w_timer_run;

   // Counting stops the moment the round is restarted or leaves ARMED.
   assign w_timer_run = (r_state == ST_ARMED) && !bus.round_start;

   always_ff @(posedge board_clk) begin
      if (rst_btn || bus.round_start) begin
         r_prescale <= '0;
         r_tick_cnt <= '0;
      end else if (w_timer_run) begin
         if (r_prescale == PRE_LAST) begin
            r_prescale <= '0;
            r_tick_cnt <= tick_sat_inc(r_tick_cnt);
         end else begin
            r_prescale <= r_prescale + PRE_W'(1);
         end
      end
   end

   always_ff @(posedge board_clk) begin
      if (rst_btn) begin
         r_reaction_ticks <= '0;
      end else if (w_capture) begin
         r_reaction_ticks <= r_tick_cnt;
      end
   end

   assign bus.reaction_ticks = r_reaction_ticks;
`else
   assign bus.reaction_ticks = '0;
`endif

   assign bus.in_valid   = r_in_valid;
   assign bus.in_pattern = r_in_pattern;
   assign bus.timeout    = r_timeout;

endmodule

// File: doc/player_input_rx.md
PLAYER_INPUT_RX -- requirements
Module: player_input_rx

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4: consecutive stable cycles required before a switch vector is accepted.
REQ-002 Parameter TICK_DIV, default 10: board_clk cycles per reaction tick.
REQ-003 board_clk  input  1  sole clock; all logic is on its rising edge.
REQ-004 rst_btn  input  1  reset; synchronous, active-high.
REQ-005 SW  input  4  raw, asynchronous player switches.
REQ-006 round_start  input  1  one-cycle pulse; a new round begins and a pattern is shown.
REQ-007 round_end  input  1  one-cycle pulse; the round window closes.
REQ-008 in_ack  input  1  the game logic has consumed the answer.
REQ-009 in_valid  output  1  the answer is held and stable.
REQ-010 in_pattern  output  4  the player's answer.
REQ-011 reaction_ticks  output  8  ticks from round_start to the answer.
REQ-012 timeout  output  1  the answer was forced by round_end with no switch change.

Function
REQ-013 SW shall pass through a 2-flop synchronizer before any other use.
REQ-014 The debounced vector shall take the synchronized value once that value has been constant for DEBOUNCE_CYCLES consecutive cycles; latency from SW to debounced is 2+DEBOUNCE_CYCLES cycles.
REQ-015 The FSM shall have three states: IDLE, ARMED and LOCKED.
REQ-016 IDLE→ARMED on round_start: latch the debounced vector as the baseline, clear the tick prescaler and counter, deassert in_valid.
REQ-017 ARMED→LOCKED on the first cycle the debounced vector differs from the baseline, capturing it in the same cycle.
REQ-018 The capture shall set in_pattern to the debounced vector, reaction_ticks to the current counter, timeout to 0, and in_valid to 1 on the following cycle.
REQ-019 ARMED→LOCKED on round_end with no change: in_pattern = debounced vector, timeout = 1, reaction_ticks = current counter.
REQ-020 If a change and round_end occur in the same cycle, the change capture shall win (timeout = 0).
REQ-021 In LOCKED, in_valid, in_pattern, reaction_ticks and timeout shall hold stable until in_ack.
REQ-022 LOCKED→IDLE on in_ack; in_valid drops the next cycle.
REQ-023 in_ack shall be ignored when in_valid = 0.
REQ-024 round_start in any state shall restart per REQ-016, abandoning any unacknowledged answer (in_valid → 0).
REQ-025 round_start together with round_end or in_ack in the same cycle: round_start shall take precedence.
REQ-026 round_end in IDLE or LOCKED shall be ignored.
REQ-027 The counter shall increment once per TICK_DIV cycles while ARMED and saturate at 255 (no wrap).
REQ-028 Outputs shall change only on board_clk edges; no combinational path shall exist from SW to any output.

Reset
REQ-029 On rst_btn: FSM = IDLE, in_valid = 0, in_pattern = 0, reaction_ticks = 0, timeout = 0, prescaler = counter = 0, synchronizer and debounced vector = 0, stability counter = 0.
REQ-030 rst_btn shall override every other input in the same cycle, including mid-round and mid-handshake.

Configuration
REQ-031 With macro REACTION_TIMER_EN defined: the prescaler and counter shall be built and reaction_ticks behaves per REQ-018/REQ-027.
REQ-032 Without REACTION_TIMER_EN: no prescaler or counter registers shall exist and reaction_ticks shall be tied to 0; all other behaviour is unchanged.

Structure
REQ-033 Shared package game_pkg shall hold the FSM state encoding, PATTERN_W = 4 and TICK_W = 8.
REQ-034 One sub-module, sw_debounce (synchronizer plus stability counter, parameter DEBOUNCE_CYCLES), shall be instantiated once.

Verification (DEBOUNCE_CYCLES=4, TICK_DIV=10)
REQ-035 Reset, then SW=4'b0000 and round_start; SW→4'b1010 clean at cycle 100 → in_valid at cycle 107, in_pattern=4'b1010, reaction_ticks=10, timeout=0; in_ack → in_valid=0 the next cycle.
REQ-036 SW=4'b0011 held, round_start, round_end after 50 cycles → in_valid, in_pattern=4'b0011, timeout=1, reaction_ticks=5.
REQ-037 Bounce: SW toggles 0000/0001 every 2 cycles for 20 cycles then settles at 0001 → exactly one capture, 0001, 6 cycles after settling; no earlier in_valid.
REQ-038 Round with no round_end or change for 3000 cycles → reaction_ticks saturates at 255 on a later change; round_start while LOCKED and unacked → in_valid=0 and the FSM returns to ARMED.
REQ-039 rst_btn asserted in ARMED and in LOCKED → all outputs 0 the next cycle; round_start and round_end in the same cycle → ARMED with cleared counter.
REQ-040 Build without REACTION_TIMER_EN and repeat REQ-035 → identical results except reaction_ticks=0.
